// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB rename tags.
// Accepts in-order commits and new renames, and serves two combinational operand lookups.
module reg_rename_file #(
  parameter int REG_COUNT      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TAG_WIDTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic [TAG_WIDTH-1:0]      issue_tag,
  input  logic                      commit_valid,
  input  logic [REG_ADDR_WIDTH-1:0] commit_rd,
  input  logic [TAG_WIDTH-1:0]      commit_tag,
  input  logic [DATA_WIDTH-1:0]     commit_data,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  output logic                      rs1_busy,
  output logic [TAG_WIDTH-1:0]      rs1_tag,
  output logic [DATA_WIDTH-1:0]     rs1_data,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      rs2_busy,
  output logic [TAG_WIDTH-1:0]      rs2_tag,
  output logic [DATA_WIDTH-1:0]     rs2_data
);

  typedef struct packed {
    logic                  busy;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } lookup_t;

  logic [DATA_WIDTH-1:0] data_q [REG_COUNT];
  logic                  busy_q [REG_COUNT];
  logic [TAG_WIDTH-1:0]  tag_q  [REG_COUNT];

  // Entry 0 is only ever written by reset, so it stays zero and never busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the whole file is reset, data included, because lookups of
      // never-written registers must return zero rather than X.
      for (int i = 0; i < REG_COUNT; i++) begin
        data_q[i] <= '0;
        busy_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else if (rdy) begin
      // NOTE: non-blocking throughout so every register sees pre-edge busy/tag
      // when deciding whether a commit retires its rename.
      for (int i = 1; i < REG_COUNT; i++) begin
        if (commit_valid && commit_rd == REG_ADDR_WIDTH'(i)) begin
          data_q[i] <= commit_data;
        end
        if (clear) begin
          busy_q[i] <= 1'b0;
          tag_q[i]  <= '0;
        end else if (issue_valid && issue_rd == REG_ADDR_WIDTH'(i)) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= issue_tag;
        end else if (commit_valid && commit_rd == REG_ADDR_WIDTH'(i) &&
                     busy_q[i] && tag_q[i] == commit_tag) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  // A commit retiring the current rename is forwarded in the same cycle,
  // independent of rdy; a newer outstanding rename keeps the register busy.
  function automatic lookup_t lookup(
    input logic [REG_ADDR_WIDTH-1:0] addr,
    input logic                      busy,
    input logic [TAG_WIDTH-1:0]      tag,
    input logic [DATA_WIDTH-1:0]     data,
    input logic                      c_valid,
    input logic [REG_ADDR_WIDTH-1:0] c_rd,
    input logic [TAG_WIDTH-1:0]      c_tag,
    input logic [DATA_WIDTH-1:0]     c_data
  );
    lookup_t r;
    r = '0;
    if (addr == '0) begin
      r = '0;
    end else if (c_valid && c_rd == addr && busy && tag == c_tag) begin
      r.data = c_data;
    end else if (busy) begin
      r.busy = 1'b1;
      r.tag  = tag;
    end else begin
      r.data = data;
    end
    return r;
  endfunction

  lookup_t rs1_res;
  lookup_t rs2_res;

  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    rs1_res = '0;
    rs2_res = '0;
    rs1_res = lookup(rs1_addr, busy_q[rs1_addr], tag_q[rs1_addr], data_q[rs1_addr],
                     commit_valid, commit_rd, commit_tag, commit_data);
    rs2_res = lookup(rs2_addr, busy_q[rs2_addr], tag_q[rs2_addr], data_q[rs2_addr],
                     commit_valid, commit_rd, commit_tag, commit_data);
  end

  assign rs1_busy = rs1_res.busy;
  assign rs1_tag  = rs1_res.tag;
  assign rs1_data = rs1_res.data;
  assign rs2_busy = rs2_res.busy;
  assign rs2_tag  = rs2_res.tag;
  assign rs2_data = rs2_res.data;

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed table-driven bench for reg_rename_file: each vector drives one cycle of
// inputs, checks both lookups before the clock edge, then lets the edge apply it.
module tb_reg_rename_file;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic          clear;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic [TW-1:0] issue_tag;
  logic          commit_valid;
  logic [AW-1:0] commit_rd;
  logic [TW-1:0] commit_tag;
  logic [DW-1:0] commit_data;
  logic [AW-1:0] rs1_addr;
  logic          rs1_busy;
  logic [TW-1:0] rs1_tag;
  logic [DW-1:0] rs1_data;
  logic [AW-1:0] rs2_addr;
  logic          rs2_busy;
  logic [TW-1:0] rs2_tag;
  logic [DW-1:0] rs2_data;

  reg_rename_file dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_data(commit_data),
    .rs1_addr(rs1_addr), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_data(rs1_data),
    .rs2_addr(rs2_addr), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_data(rs2_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rdy, clr, iv;
    logic [AW-1:0] ird;
    logic [TW-1:0] itag;
    logic          cv;
    logic [AW-1:0] crd;
    logic [TW-1:0] ctag;
    logic [DW-1:0] cdata;
    logic [AW-1:0] a1, a2;
    logic          e1b;
    logic [TW-1:0] e1t;
    logic [DW-1:0] e1d;
    logic          e2b;
    logic [TW-1:0] e2t;
    logic [DW-1:0] e2d;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic c, input logic iv, input int ird, input int itag,
                     input logic cv, input int crd, input int ctag, input logic [DW-1:0] cdata,
                     input int a1, input int a2,
                     input logic e1b, input int e1t, input logic [DW-1:0] e1d,
                     input logic e2b, input int e2t, input logic [DW-1:0] e2d);
    vec_t v;
    v.rdy = r; v.clr = c; v.iv = iv; v.ird = AW'(ird); v.itag = TW'(itag);
    v.cv = cv; v.crd = AW'(crd); v.ctag = TW'(ctag); v.cdata = cdata;
    v.a1 = AW'(a1); v.a2 = AW'(a2);
    v.e1b = e1b; v.e1t = TW'(e1t); v.e1d = e1d;
    v.e2b = e2b; v.e2t = TW'(e2t); v.e2d = e2d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic b, input logic [TW-1:0] t, input logic [DW-1:0] d,
                       input logic eb, input logic [TW-1:0] et, input logic [DW-1:0] ed);
    n_cmp++;
    if (b !== eb || t !== et || d !== ed) begin
      n_bad++;
      $display("FAIL %s: got busy=%0b tag=%0d data=%h, expected busy=%0b tag=%0d data=%h",
               name, b, t, d, eb, et, ed);
    end
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; clear = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_tag = '0;
    commit_valid = 1'b0; commit_rd = '0; commit_tag = '0; commit_data = '0;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  initial begin
    //  rdy clr iv ird itag cv crd ctag cdata        a1  a2   e1b e1t e1d           e2b e2t e2d
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,          5,  0,   0, 0, 32'h0,          0, 0, 32'h0);
    add(1, 0, 1, 3, 7,   0, 0, 0, 32'h0,          3,  3,   0, 0, 32'h0,          0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,          3,  0,   1, 7, 32'h0,          0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   1, 3, 7, 32'hDEADBEEF,   3,  5,   0, 0, 32'hDEADBEEF,   0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,          3,  3,   0, 0, 32'hDEADBEEF,   0, 0, 32'hDEADBEEF);
    add(1, 0, 1, 4, 2,   0, 0, 0, 32'h0,          4,  4,   0, 0, 32'h0,          0, 0, 32'h0);
    add(1, 0, 1, 4, 5,   0, 0, 0, 32'h0,          3,  4,   0, 0, 32'hDEADBEEF,   1, 2, 32'h0);
    add(1, 0, 0, 0, 0,   1, 4, 2, 32'h11,         4,  4,   1, 5, 32'h0,          1, 5, 32'h0);
    add(1, 0, 0, 0, 0,   1, 4, 5, 32'h22,         4,  4,   0, 0, 32'h22,         0, 0, 32'h22);
    add(1, 0, 1, 6, 1,   0, 0, 0, 32'h0,          4,  6,   0, 0, 32'h22,         0, 0, 32'h0);
    add(1, 0, 1, 6, 9,   1, 6, 1, 32'h55,         6,  6,   0, 0, 32'h55,         0, 0, 32'h55);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,          6,  6,   1, 9, 32'h0,          1, 9, 32'h0);
    add(1, 0, 0, 0, 0,   1, 6, 9, 32'h66,         6,  0,   0, 0, 32'h66,         0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,          6,  6,   0, 0, 32'h66,         0, 0, 32'h66);
    add(1, 0, 1, 1, 1,   0, 0, 0, 32'h0,          1,  0,   0, 0, 32'h0,          0, 0, 32'h0);
    add(1, 0, 1, 2, 2,   0, 0, 0, 32'h0,          1,  2,   1, 1, 32'h0,          0, 0, 32'h0);
    add(1, 0, 1, 3, 3,   0, 0, 0, 32'h0,          2,  4,   1, 2, 32'h0,          0, 0, 32'h22);
    add(1, 0, 1, 4, 4,   0, 0, 0, 32'h0,          3,  4,   1, 3, 32'h0,          0, 0, 32'h22);
    add(1, 1, 1, 9, 10,  1, 8, 0, 32'h77,         4,  8,   1, 4, 32'h0,          0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,          1,  9,   0, 0, 32'h0,          0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,          2,  3,   0, 0, 32'h0,          0, 0, 32'hDEADBEEF);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,          4,  8,   0, 0, 32'h22,         0, 0, 32'h77);
    add(1, 0, 1, 0, 3,   1, 0, 0, 32'h99,         0,  0,   0, 0, 32'h0,          0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,          0,  0,   0, 0, 32'h0,          0, 0, 32'h0);
    add(0, 0, 1, 2, 4,   1, 8, 0, 32'h12,         2,  8,   0, 0, 32'h0,          0, 0, 32'h77);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,          2,  8,   0, 0, 32'h0,          0, 0, 32'h77);
    add(1, 0, 1, 10, 6,  0, 0, 0, 32'h0,          10, 10,  0, 0, 32'h0,          0, 0, 32'h0);
    add(0, 0, 0, 0, 0,   1, 10, 6, 32'hAB,        10, 10,  0, 0, 32'hAB,         0, 0, 32'hAB);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,          10, 8,   1, 6, 32'h0,          0, 0, 32'h77);
    add(0, 1, 0, 0, 0,   0, 0, 0, 32'h0,          10, 10,  1, 6, 32'h0,          1, 6, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,          10, 8,   1, 6, 32'h0,          0, 0, 32'h77);
    add(1, 0, 1, 31, 15, 0, 0, 0, 32'h0,          31, 31,  0, 0, 32'h0,          0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   1, 31, 15, 32'hFFFFFFFF, 31, 10,  0, 0, 32'hFFFFFFFF,   1, 6, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,          31, 3,   0, 0, 32'hFFFFFFFF,   0, 0, 32'hDEADBEEF);

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rdy = vecs[i].rdy; clear = vecs[i].clr;
      issue_valid = vecs[i].iv; issue_rd = vecs[i].ird; issue_tag = vecs[i].itag;
      commit_valid = vecs[i].cv; commit_rd = vecs[i].crd; commit_tag = vecs[i].ctag;
      commit_data = vecs[i].cdata;
      rs1_addr = vecs[i].a1; rs2_addr = vecs[i].a2;
      #1;
      check($sformatf("vec%0d rs1", i), rs1_busy, rs1_tag, rs1_data, vecs[i].e1b, vecs[i].e1t, vecs[i].e1d);
      check($sformatf("vec%0d rs2", i), rs2_busy, rs2_tag, rs2_data, vecs[i].e2b, vecs[i].e2t, vecs[i].e2d);
    end

    // Reset must clear busy and data even while rdy is low.
    @(negedge clk);
    idle_inputs();
    rdy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rs1_addr = AW'(10); rs2_addr = AW'(3);
    #1;
    check("reset_rdy_low x10", rs1_busy, rs1_tag, rs1_data, 1'b0, '0, '0);
    check("reset_rdy_low x3", rs2_busy, rs2_tag, rs2_data, 1'b0, '0, '0);
    rs1_addr = AW'(31); rs2_addr = AW'(8);
    #1;
    check("reset_rdy_low x31", rs1_busy, rs1_tag, rs1_data, 1'b0, '0, '0);
    check("reset_rdy_low x8", rs2_busy, rs2_tag, rs2_data, 1'b0, '0, '0);

    // Stale-tag commit on a busy register must neither bypass nor retire it.
    @(negedge clk);
    rdy = 1'b1;
    issue_valid = 1'b1; issue_rd = AW'(7); issue_tag = TW'(12);
    @(negedge clk);
    issue_valid = 1'b0;
    commit_valid = 1'b1; commit_rd = AW'(7); commit_tag = TW'(11); commit_data = 32'h3C3C3C3C;
    rs1_addr = AW'(7); rs2_addr = AW'(7);
    #1;
    check("stale_commit bypass", rs1_busy, rs1_tag, rs1_data, 1'b1, TW'(12), '0);
    @(negedge clk);
    commit_valid = 1'b0;
    #1;
    check("stale_commit after", rs2_busy, rs2_tag, rs2_data, 1'b1, TW'(12), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_rename_file.md
Name: reg_rename_file

Overview:
- Architectural register file with per-register rename tags for the out-of-order RISC-V core.
- Receiving end of the reorder-buffer commit interface: consumes in-order commits (dest reg, ROB tag, data) and retires each register's pending rename.
- Records new renames from decode/issue.
- Serves two combinational source-operand lookups to dispatch, returning either the committed value or the ROB tag that will produce it.
- On a pipeline flush (clear), discards all speculative renames.

Parameters:
REG_COUNT, 32, number of architectural registers (x0 hardwired to zero)
REG_ADDR_WIDTH, 5, width of register index
DATA_WIDTH, 32, register data width
TAG_WIDTH, 4, ROB tag width (16-entry ROB)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
rdy  input  1  global enable; when low all state holds
clear  input  1  flush pulse from ROB; discard all renames
issue_valid  input  1  decode issuing an instruction with a destination register this cycle
issue_rd  input  REG_ADDR_WIDTH  destination register of the issuing instruction
issue_tag  input  TAG_WIDTH  ROB entry allocated to the issuing instruction
commit_valid  input  1  ROB commit write this cycle
commit_rd  input  REG_ADDR_WIDTH  committed destination register
commit_tag  input  TAG_WIDTH  ROB entry being committed
commit_data  input  DATA_WIDTH  committed value
rs1_addr  input  REG_ADDR_WIDTH  source 1 lookup index
rs1_busy  output  1  1 = value pending in ROB; use rs1_tag
rs1_tag  output  TAG_WIDTH  producing ROB tag (0 when not busy)
rs1_data  output  DATA_WIDTH  register value (0 when busy)
rs2_addr  input  REG_ADDR_WIDTH  source 2 lookup index
rs2_busy  output  1  as rs1
rs2_tag  output  TAG_WIDTH  as rs1
rs2_data  output  DATA_WIDTH  as rs1

Behaviour:
- State per register: data[DATA_WIDTH], busy, tag[TAG_WIDTH].
- Reset (rst high at posedge, regardless of rdy): all data, busy and tag fields = 0. Read outputs are combinational, so after reset every lookup returns busy=0, tag=0, data=0.
- rdy low: no state update; lookups remain live.
- x0:
  - data always 0 and never busy.
  - issue with issue_rd=0 is ignored.
  - commit with commit_rd=0 is ignored.
- Commit (posedge, rdy, commit_valid, commit_rd!=0):
  - data[commit_rd] <= commit_data unconditionally.
  - busy[commit_rd] <= 0 only if busy[commit_rd]=1 and tag[commit_rd]==commit_tag.
  - Otherwise the busy flag is untouched, because a newer rename is outstanding.
- Issue (posedge, rdy, issue_valid, issue_rd!=0, clear low): busy[issue_rd] <= 1 and tag[issue_rd] <= issue_tag.
- Issue and commit to the same register in the same cycle: the issue wins the busy/tag fields (busy stays 1, tag = issue_tag). The commit data write still occurs.
- Clear (posedge, rdy, clear high):
  - All busy <= 0 and all tag <= 0.
  - A simultaneous commit still writes data, since the commit is architectural.
  - A simultaneous issue is dropped.
- Lookup (combinational, per port, evaluated independently):
  - addr=0: busy=0, tag=0, data=0.
  - Commit bypass: if commit_valid, commit_rd==addr, busy[addr]=1 and tag[addr]==commit_tag, then busy=0, tag=0, data=commit_data.
  - Otherwise, if busy[addr]: busy=1, tag=tag[addr], data=0.
  - Otherwise: busy=0, tag=0, data=data[addr].
  - Same-cycle issue is not visible to lookups. An instruction reads its sources before its own destination is renamed, so rd==rs for the same instruction reads the old mapping.
  - Commit bypass applies even when rdy is low.
- No internal latency: a commit at edge N is visible in storage from cycle N+1, and via bypass already in cycle N.
- Tag wrap-around: the ROB guarantees a tag is not reallocated while an older instance is live. The block performs only equality compare, with no ordering arithmetic.

Test Plan:
- Reset, then read x5 and x0 -> busy=0, tag=0, data=0 on both ports.
- Issue rd=3 tag=7; next cycle rs1_addr=3 -> busy=1, tag=7. Commit rd=3 tag=7 data=0xDEADBEEF -> same cycle rs1 bypass busy=0, data=0xDEADBEEF; next cycle busy=0, data=0xDEADBEEF from storage.
- Stale commit: issue rd=4 tag=2, then issue rd=4 tag=5, then commit rd=4 tag=2 data=0x11 -> rs2 on x4 reads busy=1, tag=5. Commit rd=4 tag=5 data=0x22 -> busy=0, data=0x22.
- Same-cycle issue and commit: x6 busy with tag=1; in one cycle commit rd=6 tag=1 data=0x55 and issue rd=6 tag=9 -> lookup that cycle shows bypass busy=0, data=0x55. Next cycle busy=1, tag=9; after a later commit tag=9 data=0x66, data=0x66.
- Flush: issue rd=1..4 with tags 1..4, then clear with a simultaneous commit rd=8 tag=0 data=0x77 and issue rd=9 tag=10 -> next cycle x1..x4 and x9 are not busy, and x8 data=0x77.
- x0 and rdy: issue rd=0 tag=3 and commit rd=0 data=0x99 -> x0 reads 0, not busy. With rdy=0, issue rd=2 tag=4 -> x2 stays not busy. Reassert rdy -> state unchanged.
